// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg: shared types and default widths for the MIPS memory arbiter.
//   state_t  : arbiter FSM states (IDLE, ACCESS, DONE)
//   req_id_t : requester identity (REQ_IF fetch, REQ_D data)
//   DEF_DW / DEF_AW : default data and address widths
package mips_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {REQ_IF, REQ_D} req_id_t;
   localparam int DEF_DW = 16;
   localparam int DEF_AW = 16;
endpackage

// File: rtl/mips_mem_arbiter_pick.sv
// arb_pick: combinational winner selection between fetch and data requesters.
//   if_req, d_req : pending requests
//   last_grant    : requester granted last; a tie goes to the other one
//   grant         : selected requester (only meaningful when a request is pending)
module arb_pick
   import mips_arb_pkg::*;
(
   input  logic    if_req,
   input  logic    d_req,
   input  req_id_t last_grant,
   output req_id_t grant
);
   always_comb
      grant = (if_req && d_req) ? ((last_grant == REQ_D) ? REQ_IF : REQ_D)
                                : (d_req ? REQ_D : REQ_IF);
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between instruction fetch and data access.
//   clk, rst (async, active low)
//   if_req/if_addr -> if_ack/if_rdata        : fetch port (always reads)
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata : data port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata : shared memory command and read data
//   busy : high whenever an access is in flight
// Defining MIPS_ARB_RR_EN selects round-robin tie breaking; otherwise data has fixed priority.
module mips_mem_arbiter
   import mips_arb_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int AW      = DEF_AW,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_err
      $error("mips_mem_arbiter: MEM_LAT must be in 1..7");
   end

   state_t        state, state_nx;
   logic [2:0]    cnt;
   req_id_t       win, grant, last_grant;
   logic [AW-1:0] r_addr;
   logic          r_we;
   logic [DW-1:0] r_wdata;
   logic          start, last;

   assign start = (state == IDLE) && (if_req || d_req);
   assign last  = (state == ACCESS) && (cnt == '0);

   arb_pick u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant      (grant)
   );

`ifdef MIPS_ARB_RR_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) last_grant <= REQ_D;
      else if (start) last_grant <= grant;
`else
   // Pinning last_grant to fetch makes every tie resolve to data.
   assign last_grant = REQ_IF;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx  = state;
      if (start) state_nx = ACCESS;
      else if (last) state_nx = DONE;
      else if (state == DONE) state_nx = IDLE;
      busy      = state != IDLE;
      mem_en    = state == ACCESS;
      mem_we    = mem_en && r_we;
      mem_addr  = mem_en ? r_addr : '0;
      mem_wdata = mem_en ? r_wdata : '0;
      if_ack    = (state == DONE) && (win == REQ_IF);
      d_ack     = (state == DONE) && (win == REQ_D);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt      <= '0;
         win      <= REQ_IF;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_wdata  <= '0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         if (start) begin
            win     <= grant;
            r_addr  <= (grant == REQ_D) ? d_addr : if_addr;
            r_we    <= (grant == REQ_D) && d_we;
            r_wdata <= (grant == REQ_D) ? d_wdata : '0;
            cnt     <= 3'(MEM_LAT - 1);
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 3'd1;
         end
         if (last && !r_we && win == REQ_D) d_rdata <= mem_rdata;
         if (last && !r_we && win == REQ_IF) if_rdata <= mem_rdata;
      end
endmodule
